// File: rtl/ppg_pkg.sv
// rtl/ppg_pkg.sv - shared constants and channel type for the PPG front-end model
package ppg_pkg;
  localparam int ADC_MID = 127;
  localparam int DC_W    = 7;
  localparam int GAIN_W  = 4;
  localparam int DRIVE_W = 4;
  localparam int ADC_W   = 8;

  typedef enum logic [1:0] {CH_DARK, CH_IR, CH_RED} ch_e;

  // Exactly one LED lit selects that channel; none or both means dark.
  function automatic ch_e decode_channel(input logic ir, input logic red);
    if (ir && !red) return CH_IR;
    if (red && !ir) return CH_RED;
    return CH_DARK;
  endfunction
endpackage

// File: rtl/ppg_pulse_gen.sv
// rtl/ppg_pulse_gen.sv - triangle AC generator stepping once every PULSE_DIV cycles
module ppg_pulse_gen #(
  parameter int AC_AMP    = 8,
  parameter int PULSE_DIV = 64
) (
  input  logic              clk,
  input  logic              rst,
  output logic signed [6:0] o_ac
);
  localparam int PW = (PULSE_DIV > 1) ? $clog2(PULSE_DIV) : 1;
  localparam logic signed [6:0] AMP_P = 7'(AC_AMP);
  localparam logic signed [6:0] AMP_N = -AMP_P;

  logic [PW-1:0]      r_presc;
  logic               r_up;
  logic signed [6:0]  r_ac;
  logic               w_step;
  logic signed [6:0]  w_next;

  assign w_step = (r_presc == PW'(PULSE_DIV - 1));
  assign w_next = r_up ? r_ac + 7'sd1 : r_ac - 7'sd1;
  assign o_ac   = r_ac;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_ac    <= '0;
      r_up    <= 1'b1;
    end else begin
      r_presc <= w_step ? '0 : r_presc + PW'(1);
      // Zero amplitude keeps the counter pinned at 0 instead of oscillating.
      if (w_step && AC_AMP > 0) begin
        r_ac <= w_next;
        if (w_next == AMP_P)      r_up <= 1'b0;
        else if (w_next == AMP_N) r_up <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/ppg_afe_model.sv
// rtl/ppg_afe_model.sv - settling-aware, saturating PPG analog front-end responder
module ppg_afe_model
  import ppg_pkg::*;
#(
  parameter int IR_BASE       = 160,
  parameter int RED_BASE      = 96,
  parameter int AC_AMP        = 8,
  parameter int PULSE_DIV     = 64,
  parameter int SETTLE_CYCLES = 16,
  parameter int FILT_SHIFT    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] DC_Comp,
  input  logic [3:0] PGA_Gain,
  input  logic [3:0] LED_Drive,
  input  logic       LED_IR,
  input  logic       LED_RED,
  input  logic       CLK_Filter,
  output logic [7:0] ADC,
  output logic       adc_valid,
  output logic       adc_sat
);
  localparam int AW = 8 + FILT_SHIFT;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  ch_e                w_ch;
  logic [7:0]         w_base;
  logic [4:0]         w_dp1;
  logic [11:0]        w_prod;
  logic [7:0]         w_photo;
  logic signed [6:0]  w_ac;
  logic signed [6:0]  w_ac_eff;
  logic signed [9:0]  w_v;
  logic [4:0]         w_gp1;
  logic signed [13:0] w_g;
  logic signed [13:0] w_sum;
  logic [7:0]         w_raw;
  logic               w_sat;
  logic               w_chg;
  logic               w_edge;

  logic signed [9:0]  r_v;
  logic [3:0]         r_gain;
  logic [7:0]         r_raw;
  logic               r_sat;
  logic [AW-1:0]      r_acc;
  logic               r_sat_f;
  logic [6:0]         r_dc_q;
  logic [3:0]         r_gain_q;
  logic [3:0]         r_drive_q;
  ch_e                r_ch_q;
  logic [SW-1:0]      r_settle;
  logic               r_cf_q;

  ppg_pulse_gen #(.AC_AMP(AC_AMP), .PULSE_DIV(PULSE_DIV)) u_pulse (
    .clk  (clk),
    .rst  (rst),
    .o_ac (w_ac)
  );

  assign w_ch     = decode_channel(LED_IR, LED_RED);
  assign w_base   = (w_ch == CH_IR) ? 8'(IR_BASE) : (w_ch == CH_RED) ? 8'(RED_BASE) : 8'd0;
  assign w_dp1    = {1'b0, LED_Drive} + 5'd1;
  assign w_prod   = {4'd0, w_base} * {7'd0, w_dp1};
  assign w_photo  = 8'(w_prod >> 4);
  assign w_ac_eff = (w_ch == CH_DARK) ? 7'sd0 : w_ac;
  assign w_v      = $signed({2'b00, w_photo}) + $signed({{3{w_ac_eff[6]}}, w_ac_eff})
                  - $signed({3'b000, DC_Comp});

  // Gain travels with v so each pipeline value uses a coherent control set.
  assign w_gp1 = {1'b0, r_gain} + 5'd1;
  assign w_g   = $signed({{4{r_v[9]}}, r_v}) * $signed({9'd0, w_gp1});
  assign w_sum = w_g + 14'sd127;
  assign w_sat = (w_sum < 14'sd0) || (w_sum > 14'sd255);
  assign w_raw = (w_sum < 14'sd0) ? 8'd0 : (w_sum > 14'sd255) ? 8'd255 : w_sum[7:0];

  assign w_chg  = (DC_Comp != r_dc_q) || (PGA_Gain != r_gain_q) ||
                  (LED_Drive != r_drive_q) || (w_ch != r_ch_q);
  assign w_edge = CLK_Filter & ~r_cf_q;
  assign adc_valid = (r_settle == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v       <= '0;
      r_gain    <= '0;
      r_raw     <= 8'(ADC_MID);
      r_sat     <= 1'b0;
      r_acc     <= AW'(ADC_MID) << FILT_SHIFT;
      r_sat_f   <= 1'b0;
      r_dc_q    <= DC_Comp;
      r_gain_q  <= PGA_Gain;
      r_drive_q <= LED_Drive;
      r_ch_q    <= w_ch;
      r_settle  <= SW'(SETTLE_CYCLES);
      r_cf_q    <= 1'b0;
      ADC       <= 8'(ADC_MID);
      adc_sat   <= 1'b0;
    end else begin
      r_v       <= w_v;
      r_gain    <= PGA_Gain;
      r_raw     <= w_raw;
      r_sat     <= w_sat;
      // Modular arithmetic is safe: the settled result always fits AW bits.
      r_acc     <= r_acc + AW'(r_raw) - (r_acc >> FILT_SHIFT);
      r_sat_f   <= r_sat;
      r_dc_q    <= DC_Comp;
      r_gain_q  <= PGA_Gain;
      r_drive_q <= LED_Drive;
      r_ch_q    <= w_ch;
      if (w_chg)                r_settle <= SW'(SETTLE_CYCLES);
      else if (r_settle != '0)  r_settle <= r_settle - SW'(1);
      r_cf_q    <= CLK_Filter;
      if (w_edge) begin
        ADC     <= 8'(r_acc >> FILT_SHIFT);
        adc_sat <= r_sat_f;
      end
    end
  end
endmodule

// File: tb/tb_ppg_afe_model.sv
// tb/tb_ppg_afe_model.sv - scoreboard bench for two ppg_afe_model configurations
module tb_ppg_afe_model;
  localparam int AMP_A = 4, PD_A = 3,  FS_A = 0, ST_A = 16;
  localparam int AMP_B = 0, PD_B = 64, FS_B = 2, ST_B = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] dc = 7'd127;
  logic [3:0] gain = 4'd0;
  logic [3:0] drive = 4'd15;
  logic       led_ir = 1'b1;
  logic       led_red = 1'b0;
  logic       cf = 1'b0;
  logic [7:0] adc_a, adc_b;
  logic       val_a, val_b, sat_a, sat_b;

  always #5 clk = ~clk;

  ppg_afe_model #(.IR_BASE(160), .RED_BASE(96), .AC_AMP(AMP_A), .PULSE_DIV(PD_A),
                  .SETTLE_CYCLES(ST_A), .FILT_SHIFT(FS_A)) u_a (
    .clk(clk), .rst(rst), .DC_Comp(dc), .PGA_Gain(gain), .LED_Drive(drive),
    .LED_IR(led_ir), .LED_RED(led_red), .CLK_Filter(cf),
    .ADC(adc_a), .adc_valid(val_a), .adc_sat(sat_a));

  ppg_afe_model #(.IR_BASE(160), .RED_BASE(96), .AC_AMP(AMP_B), .PULSE_DIV(PD_B),
                  .SETTLE_CYCLES(ST_B), .FILT_SHIFT(FS_B)) u_b (
    .clk(clk), .rst(rst), .DC_Comp(dc), .PGA_Gain(gain), .LED_Drive(drive),
    .LED_IR(led_ir), .LED_RED(led_red), .CLK_Filter(cf),
    .ADC(adc_b), .adc_valid(val_b), .adc_sat(sat_b));

  typedef struct {
    int cyc;
    int inst;
    int kind;
    int a;
    int b;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int rst_cyc;
  int prev_cf;
  int p_dc, p_gain, p_drive, p_ch;
  int last_chg [2];
  int acc      [2];
  int sat_f    [2];
  int rq_raw   [2][2];
  int rq_sat   [2][2];

  function automatic int p_amp(int k); return (k == 0) ? AMP_A : AMP_B; endfunction
  function automatic int p_pd (int k); return (k == 0) ? PD_A  : PD_B;  endfunction
  function automatic int p_fs (int k); return (k == 0) ? FS_A  : FS_B;  endfunction
  function automatic int p_st (int k); return (k == 0) ? ST_A  : ST_B;  endfunction

  function automatic int chan(logic ir, logic red);
    if (ir && !red) return 1;
    if (red && !ir) return 2;
    return 0;
  endfunction

  // Triangle value after a given number of steps: up to +amp, down to -amp, back to 0.
  function automatic int tri_ac(int amp, int steps);
    int p;
    if (amp == 0) return 0;
    p = steps % (4 * amp);
    if (p <= amp) return p;
    if (p <= 3 * amp) return 2 * amp - p;
    return p - 4 * amp;
  endfunction

  function automatic void calc_raw(input int ch, input int dcv, input int g, input int dr,
                                   input int acv, output int raw, output int sat);
    int photo, v, x;
    photo = (ch == 1) ? (160 * (dr + 1)) / 16 : (ch == 2) ? (96 * (dr + 1)) / 16 : 0;
    v = photo + ((ch == 0) ? 0 : acv) - dcv;
    x = 127 + v * (g + 1);
    sat = (x < 0 || x > 255) ? 1 : 0;
    raw = (x < 0) ? 0 : (x > 255) ? 255 : x;
  endfunction

  function automatic exp_t mk(int c, int i, int k, int a, int b);
    exp_t e;
    e.cyc = c; e.inst = i; e.kind = k; e.a = a; e.b = b;
    return e;
  endfunction

  // Reference model: predicts what each instance shows after this edge.
  always @(posedge clk) begin : model
    int ch, acv, raw, sat;
    bit chg;
    cyc = cyc + 1;
    ch = chan(led_ir, led_red);
    if (rst) begin
      rst_cyc = cyc;
      prev_cf = 0;
      p_dc = dc; p_gain = gain; p_drive = drive; p_ch = ch;
      for (int k = 0; k < 2; k++) begin
        last_chg[k] = cyc;
        acc[k]      = 127 << p_fs(k);
        sat_f[k]    = 0;
        rq_raw[k][0] = 127; rq_raw[k][1] = 127;
        rq_sat[k][0] = 0;   rq_sat[k][1] = 0;
        sb_q.push_back(mk(cyc, k, 0, 127, 0));
        sb_q.push_back(mk(cyc, k, 1, 0, 0));
      end
    end else begin
      chg = (dc != p_dc) || (gain != p_gain) || (drive != p_drive) || (ch != p_ch);
      p_dc = dc; p_gain = gain; p_drive = drive; p_ch = ch;
      for (int k = 0; k < 2; k++) begin
        if (chg) last_chg[k] = cyc;
        if (cf && prev_cf == 0)
          sb_q.push_back(mk(cyc, k, 0, acc[k] >> p_fs(k), sat_f[k]));
        acc[k]   = acc[k] + rq_raw[k][0] - (acc[k] >> p_fs(k));
        sat_f[k] = rq_sat[k][0];
        acv = tri_ac(p_amp(k), (cyc - 1 - rst_cyc) / p_pd(k));
        calc_raw(ch, dc, gain, drive, acv, raw, sat);
        rq_raw[k][0] = rq_raw[k][1]; rq_sat[k][0] = rq_sat[k][1];
        rq_raw[k][1] = raw;          rq_sat[k][1] = sat;
        sb_q.push_back(mk(cyc, k, 1, (cyc - last_chg[k] >= p_st(k)) ? 1 : 0, 0));
      end
      prev_cf = cf;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    int act_adc, act_sat, act_val;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      act_adc = (e.inst == 0) ? int'(adc_a) : int'(adc_b);
      act_sat = (e.inst == 0) ? int'(sat_a) : int'(sat_b);
      act_val = (e.inst == 0) ? int'(val_a) : int'(val_b);
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL stale_entry inst%0d cyc %0d got_cyc %0d exp_cyc %0d", e.inst, cyc, cyc, e.cyc);
      end else if (e.kind == 0) begin
        if (act_adc != e.a || act_sat != e.b) begin
          errors++;
          $display("FAIL sample inst%0d cyc %0d got adc=%0d sat=%0d exp adc=%0d sat=%0d",
                   e.inst, cyc, act_adc, act_sat, e.a, e.b);
        end
      end else begin
        if (act_val != e.a) begin
          errors++;
          $display("FAIL adc_valid inst%0d cyc %0d got %0d exp %0d", e.inst, cyc, act_val, e.a);
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe();
    cf = 1'b1; tick(1);
    cf = 1'b0; tick(2);
  endtask

  task automatic apply(logic ir, logic red, int d, int g, int dr);
    led_ir = ir; led_red = red;
    dc = 7'(d); gain = 4'(g); drive = 4'(dr);
  endtask

  typedef struct { logic ir; logic red; int d; int g; int dr; } vec_t;
  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 127, 0, 15};
    vecs[1] = '{1'b1, 1'b0, 120, 3, 15};
    vecs[2] = '{1'b1, 1'b0, 127, 3, 15};
    vecs[3] = '{1'b1, 1'b1, 64, 0, 15};
    vecs[4] = '{1'b1, 1'b1, 64, 15, 15};
    vecs[5] = '{1'b0, 1'b0, 0, 0, 0};
    vecs[6] = '{1'b0, 1'b1, 127, 0, 15};
    vecs[7] = '{1'b1, 1'b0, 0, 15, 0};

    tick(3);
    rst = 1'b0;
    tick(20);
    cf = 1'b1; tick(5);
    cf = 1'b0; tick(2);

    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].ir, vecs[i].red, vecs[i].d, vecs[i].g, vecs[i].dr);
      tick(20);
      strobe();
    end

    apply(1'b1, 1'b0, 100, 0, 15); tick(5);
    apply(1'b1, 1'b0, 101, 0, 15); tick(25);
    strobe();

    apply(1'b1, 1'b0, 127, 0, 15); tick(20);
    for (int i = 0; i < 40; i++) begin
      cf = ~cf; tick(1);
    end
    cf = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) rst = 1'b1;
      else rst = 1'b0;
      if ($urandom_range(0, 19) == 0)
        apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 127),
              $urandom_range(0, 15), $urandom_range(0, 15));
      cf = ($urandom_range(0, 3) == 0) ? ~cf : cf;
      tick(1);
    end
    rst = 1'b0;
    cf = 1'b0;
    tick(4);
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ppg_afe_model.md
# ppg_afe_model

Synthesizable responder model of the pulse-oximeter analog front end: consumes the controller's DC_Comp, PGA_Gain, LED_Drive, LED_IR/LED_RED and CLK_Filter outputs and returns the 8-bit ADC sample the controller calibrates against. It closes the loop for Controller2 in simulation and FPGA bring-up with deterministic, settling-aware, saturating behaviour plus a synthetic pulsatile (AC) component.

## Interface
- IR_BASE, 160: IR photocurrent at full drive (0..255)
- RED_BASE, 96: RED photocurrent at full drive (0..255)
- AC_AMP, 8: triangle AC amplitude, counts (0..63)
- PULSE_DIV, 64: clk cycles per AC step (≥1)
- SETTLE_CYCLES, 16: cycles ADC is not valid after any control change (≥1)
- FILT_SHIFT, 0: IIR shift; 0 = filter bypassed
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- DC_Comp  in  7  DC offset subtracted before gain
- PGA_Gain  in  4  gain code, gain = PGA_Gain+1
- LED_Drive  in  4  LED current code
- LED_IR, LED_RED  in  1 each  channel select
- CLK_Filter  in  1  sample strobe; rising edge requests a sample
- ADC  out  8  sampled converter output
- adc_valid  out  1  high when front end settled
- adc_sat  out  1  last sample clipped at 0 or 255

## Operation
- Channel: IR if LED_IR&!LED_RED; RED if LED_RED&!LED_IR; else DARK (photo = 0).
- photo = (BASE * (LED_Drive+1)) >> 4, 8-bit unsigned; BASE = IR_BASE or RED_BASE.
- AC: triangle counter ac in [-AC_AMP, +AC_AMP], steps ±1 every PULSE_DIV cycles, reverses direction on reaching either bound; reset ac=0, direction up. Applied to IR/RED only, never DARK.
- v = photo + ac - DC_Comp, 10-bit signed (range -190..318).
- g = v * (PGA_Gain+1), 14-bit signed; raw = 127 + g, saturate to [0,255]; sat_raw = clip occurred.
- Filter: acc (8+FILT_SHIFT bits) <= acc + raw - (acc >> FILT_SHIFT) each cycle; filt = acc >> FILT_SHIFT. FILT_SHIFT=0: filt = raw.
- Settling: registered copies of DC_Comp, PGA_Gain, LED_Drive, channel; any difference loads settle counter with SETTLE_CYCLES, else it decrements to 0 and holds. adc_valid = (counter == 0).
- Sampling: CLK_Filter registered into cf_q; edge = CLK_Filter & !cf_q. On edge: ADC <= filt, adc_sat <= sat of that pipeline value. ADC updates regardless of adc_valid (unsettled samples are legal but flagged by adc_valid=0).
- DARK channel still produces v = -DC_Comp.

## Timing
- Reset (rst high at clk edge): ADC=127, adc_valid=0, adc_sat=0, settle counter=SETTLE_CYCLES, acc=127<<FILT_SHIFT, cf_q=0, ac=0, PULSE_DIV prescaler=0, input copies = current inputs.
- Pipeline: stage1 registers v; stage2 registers raw/sat_raw; stage3 filter acc. Input change at edge n reaches filt at edge n+3 (FILT_SHIFT=0).
- Edge detected in cycle n (CLK_Filter high, cf_q low) -> ADC updated at edge n+1 with filt current in cycle n. CLK_Filter held high yields one sample only.
- Control change in cycle n -> adc_valid low from edge n+1 for SETTLE_CYCLES cycles; changes during settling restart the count.
- Simultaneous change and CLK_Filter edge: sample taken, adc_valid drops same edge.
- rst asserted mid-operation overrides everything in that cycle.

## Structure
- Package ppg_pkg: ADC_MID=127, width constants (DC 7, GAIN 4, DRIVE 4, ADC 8), channel enum {CH_DARK, CH_IR, CH_RED}; shared with Controller2 benches.
- Sub-module ppg_pulse_gen: triangle AC generator (prescaler, up/down counter, bound reversal), params AC_AMP, PULSE_DIV.

## Test plan
All with IR_BASE=160, AC_AMP=0, FILT_SHIFT=0, LED_Drive=15 (photo=160) unless stated.
- IR, DC_Comp=127, PGA_Gain=0, strobe after settle -> ADC=160, adc_valid=1, adc_sat=0.
- IR, DC_Comp=120, PGA_Gain=3: v=40, g=160 -> ADC=255, adc_sat=1; DC_Comp=127, PGA_Gain=3 -> ADC=255, adc_sat=1; PGA_Gain=0, DC_Comp=127 -> ADC=160.
- Both LEDs high, DC_Comp=64, PGA_Gain=0 -> ADC=63; DC_Comp=64, PGA_Gain=15 -> ADC=0, adc_sat=1.
- Change DC_Comp at cycle n -> adc_valid 0 for exactly 16 cycles; second change at n+5 extends to n+21.
- AC_AMP=4, PULSE_DIV=1, DC_Comp=127, gain 0, strobe every cycle -> ADC sweeps 160..164..156..160 triangle, period 16 steps.
- FILT_SHIFT=2, step raw 127->159 -> ADC rises monotonically, reaches exactly 159, never overshoots.
